// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch + LSU) in front of a single-port, 1-cycle-latency SRAM.
// Data has fixed priority; a starvation counter forces an instruction grant after MAX_STALL lost cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int MAX_STALL  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // instruction fetch port
    input  logic                          instr_req_i,
    input  logic [ADDR_WIDTH-1:0]         instr_addr_i,
    output logic                          instr_gnt_o,
    output logic                          instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]         instr_rdata_o,
    output logic                          instr_err_o,
    // data (LSU) port
    input  logic                          data_req_i,
    input  logic [ADDR_WIDTH-1:0]         data_addr_i,
    input  logic                          data_we_i,
    input  logic [DATA_WIDTH/8-1:0]       data_be_i,
    input  logic [DATA_WIDTH-1:0]         data_wdata_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    output logic [DATA_WIDTH-1:0]         data_rdata_o,
    output logic                          data_err_o,
    // SRAM side
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0]  mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]       mem_be_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);
    // Handshake: a request is held with req=1 until gnt=1 in the same cycle;
    // the granted port sees rvalid=1 for exactly one cycle, one cycle later.

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int MA_W = $clog2(MEM_WORDS);
    localparam int SC_W = $clog2(MAX_STALL + 1);
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS * 4);
    localparam logic [SC_W-1:0]     STALL_MAX  = SC_W'(MAX_STALL);

    logic [SC_W-1:0]       r_stall_cnt;
    logic                  r_tag_valid;
    logic                  r_tag_data;
    logic                  r_tag_err;
    logic                  r_tag_read;

    logic                  w_instr_gnt;
    logic                  w_data_gnt;
    logic                  w_any_gnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_err;
    logic                  w_mem_go;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Data wins unless the fetch port has already lost MAX_STALL cycles in a row.
    always_comb begin
        w_instr_gnt = 1'b0;
        w_data_gnt  = 1'b0;
        if (!rst_i) begin
            if (data_req_i && (!instr_req_i || (r_stall_cnt < STALL_MAX))) begin
                w_data_gnt = 1'b1;
            end else if (instr_req_i) begin
                w_instr_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_instr_gnt | w_data_gnt;
    assign w_addr    = w_data_gnt ? data_addr_i : instr_addr_i;
    assign w_err     = ({1'b0, w_addr} >= BYTE_LIMIT) || (w_addr[1:0] != 2'b00);
    assign w_mem_go  = w_any_gnt && !w_err;

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_mem_go) begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_addr[MA_W+1:2];
            if (w_data_gnt) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = {BE_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_tag_valid <= 1'b0;
            r_tag_data  <= 1'b0;
            r_tag_err   <= 1'b0;
            r_tag_read  <= 1'b0;
        end else begin
            if (!instr_req_i || w_instr_gnt) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt < STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            r_tag_valid <= w_any_gnt;
            r_tag_data  <= w_data_gnt;
            r_tag_err   <= w_err;
            r_tag_read  <= !(w_data_gnt && data_we_i);
        end
    end

    // Read data only passes through for a good read; writes and errors return zero.
    assign w_rdata = (r_tag_valid && !r_tag_err && r_tag_read) ? mem_rdata_i : '0;

    assign instr_rvalid_o = r_tag_valid && !r_tag_data;
    assign data_rvalid_o  = r_tag_valid && r_tag_data;
    assign instr_err_o    = instr_rvalid_o && r_tag_err;
    assign data_err_o     = data_rvalid_o && r_tag_err;
    assign instr_rdata_o  = instr_rvalid_o ? w_rdata : '0;
    assign data_rdata_o   = data_rvalid_o ? w_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked by a
// reference model (grant rule + word memory) feeding per-port expected-response queues.
module tb_mem_port_arbiter;
    localparam int MEM_WORDS = 1024;
    localparam int MAX_STALL = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        i_req;
    logic [31:0] i_addr;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] sram_q;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(d_req), .data_addr_i(d_addr), .data_we_i(d_we), .data_be_i(d_be),
        .data_wdata_i(d_wdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(sram_q)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- SRAM model driven by the DUT ----------------
    bit [31:0] sram [0:MEM_WORDS-1];
    bit        sram_wr [0:MEM_WORDS-1];

    always @(posedge clk) begin : sram_model
        logic [31:0] cur;
        cur = sram_wr[mem_addr_o] ? sram[mem_addr_o] : init_word(int'(mem_addr_o));
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) if (mem_be_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
                sram[mem_addr_o]    <= cur;
                sram_wr[mem_addr_o] <= 1'b1;
            end else begin
                sram_q <= cur;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [48:0] exp_i_q[$];   // {due_cycle[15:0], err, rdata[31:0]}
    logic [48:0] exp_d_q[$];
    bit [31:0] ref_mem [0:MEM_WORDS-1];
    int    ref_stall = 0;
    logic  last_ig, last_dg, prev_rst;
    logic  mon_en = 1'b0;
    string pat;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model + cycle driver ----------------
    task automatic step();
        logic        exp_ig, exp_dg, err;
        logic [31:0] a, rd, nw;
        int          w;
        @(negedge clk);
        if (prev_rst) begin
            check("post_rst_instr_rvalid", instr_rvalid_o, 0);
            check("post_rst_instr_rdata", instr_rdata_o, 0);
            check("post_rst_instr_err", instr_err_o, 0);
            check("post_rst_data_rvalid", data_rvalid_o, 0);
            check("post_rst_data_rdata", data_rdata_o, 0);
            check("post_rst_data_err", data_err_o, 0);
        end
        exp_ig = 1'b0;
        exp_dg = 1'b0;
        if (!rst_i) begin
            if (d_req && (!i_req || ref_stall < MAX_STALL)) exp_dg = 1'b1;
            else if (i_req) exp_ig = 1'b1;
        end
        check("instr_gnt", instr_gnt_o, exp_ig);
        check("data_gnt", data_gnt_o, exp_dg);
        if (exp_ig || exp_dg) begin
            a   = exp_dg ? d_addr : i_addr;
            err = (a >= 32'(MEM_WORDS * 4)) || (a[1:0] != 2'b00);
            rd  = '0;
            check("mem_req", mem_req_o, !err);
            if (!err) begin
                w = int'(a >> 2);
                check("mem_addr", mem_addr_o, 64'(w));
                check("mem_we", mem_we_o, exp_dg && d_we);
                check("mem_be", mem_be_o, exp_dg ? d_be : 4'hF);
                check("mem_wdata", mem_wdata_o, exp_dg ? d_wdata : 32'h0);
                if (exp_dg && d_we) begin
                    nw = ref_mem[w];
                    for (int b = 0; b < 4; b++) if (d_be[b]) nw[8*b +: 8] = d_wdata[8*b +: 8];
                    ref_mem[w] = nw;
                end else begin
                    rd = ref_mem[w];
                end
            end
            if (exp_dg) begin
                exp_d_q.push_back({16'(cyc + 1), err, rd});
                pat = {pat, "D"};
            end else begin
                exp_i_q.push_back({16'(cyc + 1), err, rd});
                pat = {pat, "I"};
            end
        end else begin
            check("mem_req_idle", mem_req_o, 0);
        end
        if (rst_i || !i_req || exp_ig) ref_stall = 0;
        else if (ref_stall < MAX_STALL) ref_stall++;
        last_ig  = exp_ig;
        last_dg  = exp_dg;
        prev_rst = rst_i;
        @(posedge clk);
        #1;
    endtask

    task automatic data_op(logic [31:0] addr, logic we, logic [3:0] be, logic [31:0] wdata);
        d_req = 1'b1; d_addr = addr; d_we = we; d_be = be; d_wdata = wdata;
        step();
        d_req = 1'b0;
    endtask

    task automatic instr_op(logic [31:0] addr);
        i_req = 1'b1; i_addr = addr;
        step();
        i_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'h1000 + 32'(4 * $urandom_range(0, 15));
        if (k == 1) return 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        return 32'(4 * $urandom_range(0, 31));
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [48:0] e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (exp_i_q.size() > 0 && exp_i_q[0][48:33] == 16'(cyc)) begin
                e = exp_i_q.pop_front();
                check("instr_rvalid", instr_rvalid_o, 1);
                check("instr_err", instr_err_o, e[32]);
                check("instr_rdata", instr_rdata_o, e[31:0]);
            end else begin
                check("instr_rvalid_idle", instr_rvalid_o, 0);
            end
            if (exp_d_q.size() > 0 && exp_d_q[0][48:33] == 16'(cyc)) begin
                e = exp_d_q.pop_front();
                check("data_rvalid", data_rvalid_o, 1);
                check("data_err", data_err_o, e[32]);
                check("data_rdata", data_rdata_o, e[31:0]);
            end else begin
                check("data_rvalid_idle", data_rvalid_o, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int w = 0; w < MEM_WORDS; w++) ref_mem[w] = init_word(w);
        rst_i = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
        prev_rst = 1'b0;
        step();
        step();
        rst_i  = 1'b0;
        mon_en = 1'b1;
        step();

        // data read of a known word
        data_op(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        data_op(32'h10, 1'b0, 4'hF, 32'h0);
        step();

        // sustained conflict: D,D,D,D,I repeating
        pat = "";
        i_req = 1'b1; i_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h20; d_we = 1'b0; d_be = 4'hF;
        for (int c = 0; c < 10; c++) step();
        i_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (pat == "DDDDIDDDDI") n_pass++;
        else $display("FAIL conflict_pattern: got %s expected DDDDIDDDDI", pat);
        step();

        // partial write, then read it back
        data_op(32'h8, 1'b1, 4'b0011, 32'h0000_1234);
        data_op(32'h8, 1'b0, 4'hF, 32'h0);

        // error cases: out of range fetch, misaligned load
        instr_op(32'h1000);
        data_op(32'h6, 1'b0, 4'hF, 32'h0);
        step();

        // back-to-back fetches
        i_req = 1'b1;
        i_addr = 32'h0; step();
        i_addr = 32'h4; step();
        i_addr = 32'h8; step();
        i_req = 1'b0;
        step();

        // reset while data is requesting
        rst_i = 1'b1; d_req = 1'b1; d_addr = 32'h10; d_we = 1'b0; d_be = 4'hF;
        step();
        rst_i = 1'b0; i_req = 1'b1; i_addr = 32'h4;
        step();
        d_req = 1'b0;
        step();
        i_req = 1'b0;
        step();

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            step();
            if (!i_req || last_ig) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = rand_addr();
            end
            if (!d_req || last_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = rand_addr();
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_wdata = $urandom;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        check("instr_q_drained", 64'(exp_i_q.size()), 0);
        check("data_q_drained", 64'(exp_d_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
